// File: rtl/xcorr_pkg.sv
// Shared constants, FSM state type and the saturation helper for the
// cross-correlation engine.
package xcorr_pkg;

  localparam int unsigned WIDE_W = 34;

  localparam int unsigned OFS_TMPL     = 'h00;
  localparam int unsigned OFS_SIG      = 'h20;
  localparam int unsigned OFS_CTRL     = 'h40;
  localparam int unsigned OFS_STAT     = 'h41;
  localparam int unsigned OFS_RES      = 'h80;
  localparam int unsigned REGION_WORDS = 32;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_CLR_DONE = 2;

  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;
  localparam int unsigned STAT_OVF    = 2;
  localparam int unsigned STAT_WR_ERR = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_STORE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                     hit;
    logic signed [WIDE_W-1:0] val;
  } sat_t;

  // Clamp a wide signed sum into a w-bit signed range; hit flags a clamp.
  function automatic sat_t sat_clip(input logic signed [WIDE_W-1:0] v,
                                    input int unsigned              w);
    sat_t                     r;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = {1'b0, {(WIDE_W-1){1'b1}}};
    hi = hi >>> (WIDE_W - w);
    lo = ~hi;
    r.hit = (v > hi) || (v < lo);
    if (v > hi)      r.val = hi;
    else if (v < lo) r.val = lo;
    else             r.val = v;
    return r;
  endfunction

endpackage

// File: rtl/xcorr_mac.sv
// Single shared multiply-accumulate step: signed product added to the running
// accumulator with saturation to ACC_W bits.
module xcorr_mac
  import xcorr_pkg::*;
#(
  parameter int unsigned SAMP_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [SAMP_W-1:0] i_a,
  input  logic signed [SAMP_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic                     o_ovf
);

  logic signed [2*SAMP_W-1:0] w_prod;
  logic signed [WIDE_W-1:0]   w_wide;
  sat_t                       w_sat;
  logic                       w_unused_hi;

  assign w_prod      = i_a * i_b;
  assign w_wide      = WIDE_W'(i_acc) + WIDE_W'(w_prod);
  assign w_sat       = sat_clip(w_wide, ACC_W);
  assign o_sum       = w_sat.val[ACC_W-1:0];
  assign o_ovf       = w_sat.hit;
  // Bits above ACC_W only ever hold sign copies after clamping.
  assign w_unused_hi = ^w_sat.val[WIDE_W-1:ACC_W];

endmodule

// File: rtl/xcorr_seq_engine.sv
// Avalon-MM cross-correlation coprocessor: sample/result register file and a
// sequential FSM driving one shared MAC over all taps and lags.
module xcorr_seq_engine
  import xcorr_pkg::*;
#(
  parameter int unsigned TAPS   = 16,
  parameter int unsigned LAGS   = 5,
  parameter int unsigned SAMP_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic [31:0]       readdata,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic              irq
);

  localparam int unsigned SPW  = 32 / SAMP_W;
  localparam int unsigned NSIG = TAPS + LAGS - 1;
  localparam int unsigned I_W  = $clog2(TAPS);
  localparam int unsigned K_W  = (LAGS > 1) ? $clog2(LAGS) : 1;
  localparam int unsigned S_W  = $clog2(NSIG);

  state_t r_state;
  state_t w_next;

  logic signed [SAMP_W-1:0] r_tmpl [TAPS];
  logic signed [SAMP_W-1:0] r_sig  [NSIG];
  logic signed [ACC_W-1:0]  r_res  [LAGS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [I_W-1:0]           r_i;
  logic [K_W-1:0]           r_k;
  logic                     r_done;
  logic                     r_ovf;
  logic                     r_wr_err;
  logic                     r_irq_en;
  logic [31:0]              r_readdata;

  logic [TAPS-1:0]          w_tmpl_sel;
  logic [NSIG-1:0]          w_sig_sel;
  logic [31:0]              w_rdata;
  logic                     w_busy;
  logic                     w_ctrl_wr;
  logic                     w_start;
  logic                     w_smp_wr;
  logic                     w_do_mac;
  logic                     w_do_store;
  logic                     w_last_tap;
  logic                     w_last_lag;
  logic [S_W-1:0]           w_sidx;
  logic signed [ACC_W-1:0]  w_mac_sum;
  logic                     w_mac_ovf;

  // Per-sample word decode, shared by the write path and the read mux.
  always_comb begin
    w_tmpl_sel = '0;
    w_sig_sel  = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      w_tmpl_sel[t] = (address == ADDR_W'(OFS_TMPL + t / SPW));
    end
    for (int unsigned s = 0; s < NSIG; s++) begin
      if ((s / SPW) < REGION_WORDS) begin
        w_sig_sel[s] = (address == ADDR_W'(OFS_SIG + s / SPW));
      end
    end
  end

  assign w_busy     = (r_state == S_MAC) || (r_state == S_STORE);
  assign w_ctrl_wr  = write && (address == ADDR_W'(OFS_CTRL));
  assign w_start    = w_ctrl_wr && writedata[CTRL_START] && !w_busy;
  assign w_smp_wr   = write && ((|w_tmpl_sel) || (|w_sig_sel));
  assign w_last_tap = (r_i == I_W'(TAPS - 1));
  assign w_last_lag = (r_k == K_W'(LAGS - 1));
  assign w_sidx     = S_W'(r_k) + S_W'(r_i);

  xcorr_mac #(
    .SAMP_W (SAMP_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_acc (r_acc),
    .i_a   (r_sig[w_sidx]),
    .i_b   (r_tmpl[r_i]),
    .o_sum (w_mac_sum),
    .o_ovf (w_mac_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // DONE is a single non-busy cycle, so a new start is accepted there too.
  always_comb begin
    w_next     = r_state;
    w_do_mac   = 1'b0;
    w_do_store = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_MAC;
      S_MAC: begin
        w_do_mac = 1'b1;
        if (w_last_tap) w_next = S_STORE;
      end
      S_STORE: begin
        w_do_store = 1'b1;
        w_next     = w_last_lag ? S_DONE : S_MAC;
      end
      S_DONE:  w_next = w_start ? S_MAC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned t = 0; t < TAPS; t++) r_tmpl[t] <= '0;
      for (int unsigned s = 0; s < NSIG; s++) r_sig[s] <= '0;
    end else if (write && !w_busy) begin
      for (int unsigned t = 0; t < TAPS; t++) begin
        if (w_tmpl_sel[t]) r_tmpl[t] <= writedata[(t % SPW) * SAMP_W +: SAMP_W];
      end
      for (int unsigned s = 0; s < NSIG; s++) begin
        if (w_sig_sel[s]) r_sig[s] <= writedata[(s % SPW) * SAMP_W +: SAMP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_i      <= '0;
      r_k      <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_err <= 1'b0;
      r_irq_en <= 1'b0;
      for (int unsigned k = 0; k < LAGS; k++) r_res[k] <= '0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN];
      if (w_start) begin
        r_acc    <= '0;
        r_i      <= '0;
        r_k      <= '0;
        r_done   <= 1'b0;
        r_ovf    <= 1'b0;
        r_wr_err <= 1'b0;
      end else begin
        if (w_ctrl_wr && writedata[CTRL_CLR_DONE]) r_done <= 1'b0;
        if (w_smp_wr && w_busy) r_wr_err <= 1'b1;
        if (w_do_mac) begin
          r_acc <= w_mac_sum;
          if (w_mac_ovf) r_ovf <= 1'b1;
          r_i <= w_last_tap ? '0 : r_i + 1'b1;
        end
        if (w_do_store) begin
          r_res[r_k] <= r_acc;
          if (w_last_lag) begin
            r_done <= 1'b1;
          end else begin
            r_k   <= r_k + 1'b1;
            r_acc <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      if (w_tmpl_sel[t]) w_rdata[(t % SPW) * SAMP_W +: SAMP_W] = r_tmpl[t];
    end
    for (int unsigned s = 0; s < NSIG; s++) begin
      if (w_sig_sel[s]) w_rdata[(s % SPW) * SAMP_W +: SAMP_W] = r_sig[s];
    end
    if (address == ADDR_W'(OFS_CTRL)) w_rdata[CTRL_IRQ_EN] = r_irq_en;
    if (address == ADDR_W'(OFS_STAT)) begin
      w_rdata[STAT_BUSY]   = w_busy;
      w_rdata[STAT_DONE]   = r_done;
      w_rdata[STAT_OVF]    = r_ovf;
      w_rdata[STAT_WR_ERR] = r_wr_err;
    end
    for (int unsigned k = 0; k < LAGS; k++) begin
      if (address == ADDR_W'(OFS_RES + k)) w_rdata = 32'(r_res[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_readdata <= '0;
    else if (read) r_readdata <= w_rdata;
  end

  assign readdata = r_readdata;
  assign irq      = r_done & r_irq_en;

endmodule
